// File: rtl/gpio_pkg.sv
// gpio_pkg: shared register map, ID constant, reset values and APB byte-lane helper for apb_gpio_param
// Contents:
//   gpio_reg_e  - register index decoded from PADDR[3:0]
//   ID_MAGIC/ID_REV, id_word() - identification register contents
//   REG_RST/DEB_RST - reset values (DEB resets to 1, everything else to 0)
//   lane_merge() - merges write data into an old value under PSTRB byte enables
package gpio_pkg;

    typedef enum logic [3:0] {
        IDX_ID     = 4'd0,
        IDX_DIR    = 4'd1,
        IDX_IN     = 4'd2,
        IDX_OUT    = 4'd3,
        IDX_SET    = 4'd4,
        IDX_CLR    = 4'd5,
        IDX_MODE   = 4'd6,
        IDX_IE     = 4'd7,
        IDX_POL    = 4'd8,
        IDX_TYPE   = 4'd9,
        IDX_STATUS = 4'd10,
        IDX_DEB    = 4'd11
    } gpio_reg_e;

    localparam logic [15:0] ID_MAGIC = 16'h6770;
    localparam logic [7:0]  ID_REV   = 8'h02;
    localparam logic [31:0] REG_RST  = 32'h0;
    localparam logic [31:0] DEB_RST  = 32'h1;

    function automatic logic [31:0] id_word(input int npins);
        logic [31:0] n;
        n = npins;
        return {ID_MAGIC, n[7:0], ID_REV};
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{strb[b]}};
        return (old & ~m) | (wd & m);
    endfunction

endpackage

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: input conditioning per pin - synchroniser, optional debounce, edge/level event detect
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   pin           - raw pad level
//   pol, typ      - event polarity (1 = rising/high) and type (1 = edge, 0 = level)
//   w1c           - write-one-to-clear mask for sticky edge status
//   deb           - debounce period (used only when GPIO_DEBOUNCE_EN is defined)
//   level         - conditioned pin level (the IN register)
//   status        - event status (the STATUS register)
// Build option: GPIO_DEBOUNCE_EN adds the prescaler and three-sample debounce filter.
module gpio_in_cond #(
    parameter int NPINS       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NPINS-1:0] pin,
    input  logic [NPINS-1:0] pol,
    input  logic [NPINS-1:0] typ,
    input  logic [NPINS-1:0] w1c,
    input  logic [DEB_W-1:0] deb,
    output logic [NPINS-1:0] level,
    output logic [NPINS-1:0] status
);

    logic [SYNC_STAGES-1:0][NPINS-1:0] sync;
    logic [NPINS-1:0] prev, hit, match;

    // A matching edge seen this cycle beats a simultaneous W1C.
    assign hit   = (pol & level & ~prev) | (~pol & ~level & prev);
    assign match = ~(level ^ pol);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            prev   <= '0;
            status <= '0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], pin};
            prev   <= level;
            status <= (typ & (hit | (status & ~w1c))) | (~typ & match);
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [DEB_W-1:0] cnt, lim;
    logic             tick;
    logic [NPINS-1:0] s0, s1, s2, deb_q, agree;

    // A period of 0 behaves as 1; tick fires once every lim+1 cycles.
    assign lim   = (deb == '0) ? DEB_W'(1) : deb;
    assign tick  = cnt == lim;
    assign agree = ~(s0 ^ s1) & ~(s1 ^ s2);
    assign level = deb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            s0    <= '0;
            s1    <= '0;
            s2    <= '0;
            deb_q <= '0;
        end else begin
            cnt   <= tick ? '0 : cnt + DEB_W'(1);
            s0    <= tick ? sync[SYNC_STAGES-1] : s0;
            s1    <= tick ? s0 : s1;
            s2    <= tick ? s1 : s2;
            deb_q <= (agree & s0) | (~agree & deb_q);
        end
    end
`else
    logic unused_deb;
    assign unused_deb = ^deb;
    assign level      = sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/apb_gpio_param.sv
// apb_gpio_param: APB-controlled GPIO block with push-pull/open-drain pins and per-pin interrupts
// Ports:
//   PCLK, PRESETn                       - clock, asynchronous active-low reset
//   PSELx..PWDATA, PRDATA/PREADY/PSLVERR - zero-wait-state APB slave, index = PADDR[3:0]
//   gpio_i / gpio_o / gpio_oe           - raw pin level, drive value, drive enable
//   irq                                 - registered level interrupt, |(STATUS & IE)
// Build option: GPIO_DEBOUNCE_EN enables the DEB register and input debounce.
module apb_gpio_param
    import gpio_pkg::*;
#(
    parameter int NPINS       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             PSELx,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [3:0]       PSTRB,
    input  logic [31:0]      PADDR,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    input  logic [NPINS-1:0] gpio_i,
    output logic [NPINS-1:0] gpio_o,
    output logic [NPINS-1:0] gpio_oe,
    output logic             irq
);

    logic [3:0]       idx;
    logic             access, bad, wr;
    logic [31:0]      rdata, deb_rd;
    logic [NPINS-1:0] dir, out, mode, ie, pol, typ, level, status, wmask, w1c;
    logic [DEB_W-1:0] deb;
    logic             unused_addr;

    assign unused_addr = ^PADDR[31:4];
    assign idx         = PADDR[3:0];
    assign access      = PSELx & PENABLE;
    // Indices 12..15 and writes to read-only registers are errors and change nothing.
    assign bad         = (idx[3:2] == 2'b11) | (PWRITE & (idx == IDX_ID | idx == IDX_IN));
    assign wr          = access & PWRITE & ~bad;
    assign PREADY      = access;
    assign PSLVERR     = access & bad;
    assign PRDATA      = (access & ~PWRITE) ? rdata : '0;
    assign wmask       = NPINS'(lane_merge(32'h0, PWDATA, PSTRB));
    assign w1c         = (wr && idx == IDX_STATUS) ? wmask : '0;
    assign gpio_o      = out & ~mode;
    assign gpio_oe     = dir & ~(mode & out);

    function automatic logic [NPINS-1:0] upd(input logic [NPINS-1:0] old);
        return NPINS'(lane_merge(32'(old), PWDATA, PSTRB));
    endfunction

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            dir  <= NPINS'(REG_RST);
            out  <= NPINS'(REG_RST);
            mode <= NPINS'(REG_RST);
            ie   <= NPINS'(REG_RST);
            pol  <= NPINS'(REG_RST);
            typ  <= NPINS'(REG_RST);
            irq  <= 1'b0;
        end else begin
            irq <= |(status & ie);
            if (wr) begin
                case (idx)
                    IDX_DIR:  dir  <= upd(dir);
                    IDX_OUT:  out  <= upd(out);
                    IDX_SET:  out  <= out | wmask;
                    IDX_CLR:  out  <= out & ~wmask;
                    IDX_MODE: mode <= upd(mode);
                    IDX_IE:   ie   <= upd(ie);
                    IDX_POL:  pol  <= upd(pol);
                    IDX_TYPE: typ  <= upd(typ);
                    default:  ;
                endcase
            end
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) deb <= DEB_W'(DEB_RST);
        else if (wr && idx == IDX_DEB) deb <= DEB_W'(lane_merge(32'(deb), PWDATA, PSTRB));
    end
    assign deb_rd = 32'(deb);
`else
    assign deb    = '0;
    assign deb_rd = '0;
`endif

    always_comb begin
        rdata = '0;
        case (idx)
            IDX_ID:     rdata = id_word(NPINS);
            IDX_DIR:    rdata = 32'(dir);
            IDX_IN:     rdata = 32'(level);
            IDX_OUT:    rdata = 32'(out);
            IDX_MODE:   rdata = 32'(mode);
            IDX_IE:     rdata = 32'(ie);
            IDX_POL:    rdata = 32'(pol);
            IDX_TYPE:   rdata = 32'(typ);
            IDX_STATUS: rdata = 32'(status);
            IDX_DEB:    rdata = deb_rd;
            default:    rdata = '0;
        endcase
    end

    gpio_in_cond #(
        .NPINS(NPINS),
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_W(DEB_W)
    ) u_cond (
        .clk(PCLK),
        .rst_n(PRESETn),
        .pin(gpio_i),
        .pol(pol),
        .typ(typ),
        .w1c(w1c),
        .deb(deb),
        .level(level),
        .status(status)
    );

endmodule
